ram64_gate: RTL and testbench
=============================

# ram64_gate

64-word × 16-bit read/write memory bank for the Hack computer data path; the write-side counterpart of the 16-bit selector tree. A load is routed to exactly one word through a demultiplexer tree. The addressed word is read back through a 16-bit selector tree. It is the building block for RAM512 and the data memory behind the CPU's M register.

## Interface
- WIDTH, 16, data word width in bits; fixed at 16 for Hack.
- clk  input  1  rising-edge clock for all storage.
- rst_n  input  1  asynchronous, active-low reset; clears every word.
- in  input  WIDTH  write data.
- load  input  1  write enable for the word at `address`.
- address  input  6  word select; bits [5:3] select the bank, bits [2:0] select the word within the bank.
- out  output  WIDTH  contents of the word at `address`.

## Operation
- Storage is 8 banks × 8 words of WIDTH-bit registers, 64 words total.
- Write path:
  - `load` goes through an 8-way demux on address[5:3], then an 8-way demux on address[2:0].
  - Exactly one word-enable is high when `load`=1. None is high when `load`=0.
  - The enabled word captures `in` on the rising edge of clk. All other words hold.
- Read path:
  - `out` is a combinational 8-way 16-bit select on address[2:0] inside each bank, then on address[5:3] across banks.
  - `out` always reflects the addressed word's current stored value and never reflects `in` directly.
- Reset:
  - When rst_n=0, all 64 words go to 0 immediately, independent of clk, so `out`=0 for every address.
  - While rst_n=0, `load` is ignored.
  - Deassertion is synchronised externally; the first write can occur on the first rising edge with rst_n=1.
- Address is full-range: all 64 values are valid, with no wrap-around or out-of-range case.
- There is no read enable and no handshake. A read is always valid the same cycle.

## Timing
- Write latency is 1 cycle. `in` is sampled at edge N, and `out` shows it from just after edge N, provided `address` is unchanged.
- Read latency is 0 cycles, purely combinational from `address` and storage to `out`.
- Same-cycle load and read of the same address: before the edge `out` is the old value; after the edge it is the new value. There is no write-through bypass.
- If `address` changes in the same cycle as `load`, the word selected at the edge is written. `out` follows the new address combinationally.
- Reset asserted mid-cycle with `load`=1: the reset wins, the word is 0 and no write occurs.
- Reset value of `out` is 0.

## Structure
- The shared package holds:
  - WIDTH=16
  - the address-field split constants BANK_MSB=5, BANK_LSB=3, WORD_MSB=2, WORD_LSB=0
  - NUM_BANKS=8, WORDS_PER_BANK=8
- Natural sub-module: `ram8_gate`, an 8 × WIDTH register bank with its own 3-bit dmux write and 8-way mux read, using the same clk and rst_n. ram64_gate instantiates 8 of them plus the top-level dmux8way and mux8way16.
- Use the existing 1-bit and 16-bit mux gates for the read trees. Use dmux gates for the write trees.

## Test plan
- Reset: assert rst_n=0 with random stored data, then sweep all 64 addresses. Required: `out`=0x0000 everywhere, with no clk edge needed.
- Single write: address=0x2A, in=0xBEEF, load=1 for one edge. Required: out=0xBEEF at 0x2A; addresses 0x22, 0x2B and 0x0A still read 0.
- Walking write: write in=address×0x0101 to all 64 addresses, one per cycle. Read back all 64 addresses. Required: every word matches, with no aliasing between banks.
- Load low: address=0x05, in=0xFFFF, load=0 for 3 edges. Required: word 0x05 unchanged.
- Read-during-write: word 0x3F=0x1234; apply in=0x5678, load=1 at 0x3F. Required: out=0x1234 before the edge and 0x5678 after it.
- Reset mid-operation: rst_n pulsed low between edges while load=1 at 0x10 with in=0xAAAA. Required: out=0 immediately, and word 0x10=0 after rst_n returns high.

Source files
------------

// File: rtl/ram64_gate_pkg.sv
// ram64_gate_pkg: shared widths, address split and gate helpers for the 64-word RAM
package ram64_gate_pkg;
  localparam int WIDTH          = 16;
  localparam int ADDR_W         = 6;
  localparam int BANK_MSB       = 5;
  localparam int BANK_LSB       = 3;
  localparam int WORD_MSB       = 2;
  localparam int WORD_LSB       = 0;
  localparam int NUM_BANKS      = 8;
  localparam int WORDS_PER_BANK = 8;
  function automatic logic [7:0] dmux8way(input logic d, input logic [2:0] sel);
    return {7'b0, d} << sel;
  endfunction
  function automatic logic [WIDTH-1:0] mux8way16(input logic [7:0][WIDTH-1:0] d, input logic [2:0] sel);
    return d[sel];
  endfunction
endpackage

// File: rtl/ram64_gate_if.sv
// ram64_gate_if: write data, load, address and read data of the 64-word RAM
interface ram64_gate_if;
  import ram64_gate_pkg::*;
  logic [WIDTH-1:0]  i_in;
  logic              i_load;
  logic [ADDR_W-1:0] i_address;
  logic [WIDTH-1:0]  o_out;
  modport master (output i_in, i_load, i_address, input o_out);
  modport slave  (input i_in, i_load, i_address, output o_out);
endinterface

// File: rtl/ram8_gate.sv
// ram8_gate: 8-word register bank with dmux write enables and mux read
module ram8_gate
  import ram64_gate_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         i_in,
  input  logic                     i_load,
  input  logic [WORD_MSB:WORD_LSB] i_address,
  output logic [WIDTH-1:0]         o_out
);
  logic [WORDS_PER_BANK-1:0][WIDTH-1:0] r_word;
  logic [WORDS_PER_BANK-1:0]            w_en;
  assign w_en  = dmux8way(i_load, i_address);
  assign o_out = mux8way16(r_word, i_address);
  // the single enabled word captures i_in; reset clears all words at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_word <= '0;
    else
      for (int k = 0; k < WORDS_PER_BANK; k++)
        if (w_en[k]) r_word[k] <= i_in;
endmodule

// File: rtl/ram64_gate.sv
// ram64_gate: 64 x 16 memory built from eight ram8_gate banks
module ram64_gate
  import ram64_gate_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  ram64_gate_if.slave  bus
);
  logic [NUM_BANKS-1:0]            w_bank_load;
  logic [NUM_BANKS-1:0][WIDTH-1:0] w_bank_out;
  assign w_bank_load = dmux8way(bus.i_load, bus.i_address[BANK_MSB:BANK_LSB]);
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    ram8_gate u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_in      (bus.i_in),
      .i_load    (w_bank_load[g]),
      .i_address (bus.i_address[WORD_MSB:WORD_LSB]),
      .o_out     (w_bank_out[g])
    );
  end
  assign bus.o_out = mux8way16(w_bank_out, bus.i_address[BANK_MSB:BANK_LSB]);
endmodule

// File: tb/tb_ram64_gate.sv
// tb_ram64_gate: scoreboard bench for the 64-word RAM
module tb_ram64_gate;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;
  ram64_gate_if bus();
  ram64_gate dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.i_address = a;
    bus.i_in = d;
    bus.i_load = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.o_out !== e) $display("FAIL reset_state got=%h exp=%h", bus.o_out, e); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) do_write(6'(i * 9), 16'($urandom) | 16'h0001);
    @(negedge clk);
    rst_n = 1'b0;
    for (int a = 0; a < 64; a++) begin
      bus.i_address = 6'(a);
      exp_q.push_back(16'h0000);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.o_out !== e) $display("FAIL reset_sweep addr=%0h got=%h exp=%h", a, bus.o_out, e); else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write;
    logic [5:0] addrs [4];
    addrs = '{6'h2A, 6'h22, 6'h2B, 6'h0A};
    do_write(6'h2A, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      bus.i_address = addrs[i];
      exp_q.push_back(i == 0 ? 16'hBEEF : 16'h0000);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.o_out !== e) $display("FAIL single_write addr=%h got=%h exp=%h", addrs[i], bus.o_out, e); else n_pass++;
    end
  endtask

  task automatic test_walking;
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      bus.i_address = 6'(a);
      bus.i_in = 16'(a) * 16'h0101;
      bus.i_load = 1'b1;
      exp_q.push_back(16'(a) * 16'h0101);
    end
    @(negedge clk);
    bus.i_load = 1'b0;
    for (int a = 0; a < 64; a++) begin
      bus.i_address = 6'(a);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.o_out !== e) $display("FAIL walking addr=%0h got=%h exp=%h", a, bus.o_out, e); else n_pass++;
    end
  endtask

  task automatic test_load_low;
    @(negedge clk);
    bus.i_address = 6'h05;
    bus.i_in = 16'hFFFF;
    bus.i_load = 1'b0;
    exp_q.push_back(16'h0505);
    repeat (3) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.o_out !== e) $display("FAIL load_low got=%h exp=%h", bus.o_out, e); else n_pass++;
  endtask

  task automatic test_read_during_write;
    do_write(6'h3F, 16'h1234);
    @(negedge clk);
    bus.i_address = 6'h3F;
    bus.i_in = 16'h5678;
    bus.i_load = 1'b1;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.o_out !== e) $display("FAIL rdw_before got=%h exp=%h", bus.o_out, e); else n_pass++;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.o_out !== e) $display("FAIL rdw_after got=%h exp=%h", bus.o_out, e); else n_pass++;
    bus.i_load = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.i_address = 6'h10;
    bus.i_in = 16'hAAAA;
    bus.i_load = 1'b1;
    #1;
    rst_n = 1'b0;
    exp_q.push_back(16'h0000);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.o_out !== e) $display("FAIL reset_mid_now got=%h exp=%h", bus.o_out, e); else n_pass++;
    @(posedge clk);
    #1;
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.o_out !== e) $display("FAIL reset_mid_edge got=%h exp=%h", bus.o_out, e); else n_pass++;
    @(negedge clk);
    bus.i_load = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.o_out !== e) $display("FAIL reset_mid_after got=%h exp=%h", bus.o_out, e); else n_pass++;
    bus.i_address = 6'h3F;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.o_out !== e) $display("FAIL reset_mid_other got=%h exp=%h", bus.o_out, e); else n_pass++;
  endtask

  initial begin
    bus.i_in = '0;
    bus.i_load = 1'b0;
    bus.i_address = '0;
    test_reset();
    test_single_write();
    test_walking();
    test_load_low();
    test_read_during_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
